// File: rtl/poker_dealer_pkg.sv
// Shared constants and round decode for the poker card dealer.
// Round codes, deck geometry and per-round target slot ranges.
package poker_dealer_pkg;

  localparam int DECK_SIZE = 52;
  localparam int CARD_W    = 6;
  localparam int NUM_SLOTS = 7;

  typedef enum logic [2:0] {
    PREFLOP = 3'd0,
    FLOP    = 3'd1,
    TURN    = 3'd2,
    RIVER   = 3'd3,
    TALLYUP = 3'd4
  } round_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_SCAN,
    S_FIN
  } state_e;

  localparam logic [2:0] PRE_FIRST  = 3'd0;
  localparam logic [2:0] PRE_LAST   = 3'd1;
  localparam logic [2:0] FLOP_FIRST = 3'd2;
  localparam logic [2:0] FLOP_LAST  = 3'd4;
  localparam logic [2:0] TURN_SLOT  = 3'd5;
  localparam logic [2:0] RIVER_SLOT = 3'd6;

  typedef struct packed {
    logic                 deal;
    logic [2:0]           first;
    logic [2:0]           last;
    logic [NUM_SLOTS-1:0] mask;
  } target_t;

  function automatic target_t round_target(input logic [2:0] r);
    target_t t;
    t = '0;
    case (r)
      PREFLOP: t = '{1'b1, PRE_FIRST, PRE_LAST, 7'b0000011};
      FLOP:    t = '{1'b1, FLOP_FIRST, FLOP_LAST, 7'b0011100};
      TURN:    t = '{1'b1, TURN_SLOT, TURN_SLOT, 7'b0100000};
      RIVER:   t = '{1'b1, RIVER_SLOT, RIVER_SLOT, 7'b1000000};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/poker_dealer_bitmap.sv
// Used-card set with test/set/clear and a sequential first-free scan.
// In scan mode the tested code comes from an internal pointer.
module card_bitmap
  import poker_dealer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_d,
  input  logic              i_clr,
  input  logic              i_set,
  input  logic              i_scan,
  input  logic [CARD_W-1:0] i_rand_code,
  output logic [CARD_W-1:0] o_code,
  output logic              o_free
);

  logic [DECK_SIZE-1:0] r_used;
  logic [CARD_W-1:0]    r_ptr;
  logic [CARD_W-1:0]    w_code;
  logic                 w_free;

  assign w_code = i_scan ? r_ptr : i_rand_code;
  assign w_free = (w_code < CARD_W'(DECK_SIZE)) && !r_used[w_code];
  assign o_code = w_code;
  assign o_free = w_free;

  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      r_used <= '0;
    end else if (i_clr) begin
      r_used <= '0;
    end else if (i_set && w_free) begin
      r_used[w_code] <= 1'b1;
    end
  end

  // Pointer parks at 0 outside scan so each scan starts from the bottom.
  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      r_ptr <= '0;
    end else if (!i_scan) begin
      r_ptr <= '0;
    end else if (!w_free) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/poker_dealer.sv
// Poker card dealer: draws unique cards per round from a PRNG stream,
// with a bounded-retry fallback scan so every deal terminates.
module poker_dealer
  import poker_dealer_pkg::*;
#(
  parameter int MAX_TRIES = 16,
  parameter int RAND_W    = 6
) (
  input  logic                        clk,
  input  logic                        reset_d,
  input  logic                        deal_req,
  input  logic [2:0]                  round,
  input  logic [RAND_W-1:0]           rand_in,
  output logic [CARD_W*NUM_SLOTS-1:0] cards,
  output logic [NUM_SLOTS-1:0]        card_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        seq_err
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e                      r_state;
  logic [CARD_W*NUM_SLOTS-1:0] r_cards;
  logic [NUM_SLOTS-1:0]        r_valid;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_seq_err;
  logic [2:0]                  r_slot;
  logic [2:0]                  r_last;
  logic [TW-1:0]               r_tries;

  target_t                     w_tgt;
  logic [CARD_W-1:0]           w_code;
  logic                        w_free;
  logic                        w_drawing;
  logic                        w_accept;

  assign w_tgt     = round_target(round);
  assign w_drawing = (r_state == S_DRAW) || (r_state == S_SCAN);
  assign w_accept  = w_drawing && w_free;

  card_bitmap u_bitmap (
    .clk         (clk),
    .reset_d     (reset_d),
    .i_clr       (r_state == S_CLEAR),
    .i_set       (w_accept),
    .i_scan      (r_state == S_SCAN),
    .i_rand_code (rand_in[CARD_W-1:0]),
    .o_code      (w_code),
    .o_free      (w_free)
  );

  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      r_state   <= S_IDLE;
      r_cards   <= '0;
      r_valid   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
      r_slot    <= '0;
      r_last    <= '0;
      r_tries   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
      if (w_accept) begin
        r_cards[CARD_W*r_slot +: CARD_W] <= w_code;
        r_valid[r_slot] <= 1'b1;
        r_tries <= '0;
        r_slot  <= r_slot + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (deal_req) begin
            r_slot  <= w_tgt.first;
            r_last  <= w_tgt.last;
            r_tries <= '0;
            if (round == PREFLOP) begin
              r_state <= S_CLEAR;
              r_busy  <= 1'b1;
            end else if (!w_tgt.deal) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else if (|(r_valid & w_tgt.mask)) begin
              r_state   <= S_FIN;
              r_done    <= 1'b1;
              r_seq_err <= 1'b1;
            end else begin
              r_state <= S_DRAW;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_cards <= '0;
          r_valid <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW, S_SCAN: begin
          if (w_accept) begin
            if (r_slot == r_last) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAW;
            end
          end else if (r_state == S_DRAW) begin
            if (r_tries == TW'(MAX_TRIES - 1)) begin
              r_state <= S_SCAN;
              r_tries <= '0;
            end else begin
              r_tries <= r_tries + 1'b1;
            end
          end
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cards      = r_cards;
  assign card_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign seq_err    = r_seq_err;

endmodule
